// File: rtl/sao_stat_accum_pkg.sv
// Shared types and default widths for the SAO statistics accumulator.
package sao_stat_accum_pkg;

  localparam int PIX_DEF           = 4;
  localparam int DIFF_CLIP_BIT_DEF = 4;
  localparam int N_CATE_BIT_DEF    = 5;
  localparam int SUM_BIT_DEF       = 16;
  localparam int CNT_BIT_DEF       = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/sao_stat_lane_sum.sv
// One category's beat contribution: signed diff sum and pixel count over the enabled lanes.
module sao_stat_lane_sum
  import sao_stat_accum_pkg::*;
#(
  parameter int PIX           = PIX_DEF,
  parameter int DIFF_CLIP_BIT = DIFF_CLIP_BIT_DEF,
  parameter int N_CATE_BIT    = N_CATE_BIT_DEF,
  localparam int DW           = DIFF_CLIP_BIT + 1,
  localparam int CW           = $clog2(PIX + 1),
  localparam int BSW          = DW + CW
) (
  input  logic [N_CATE_BIT-1:0]     tgt,
  input  logic [PIX*N_CATE_BIT-1:0] cate,
  input  logic [PIX*DW-1:0]         diff,
  input  logic [PIX-1:0]            pix_en,
  output logic [BSW-1:0]            beat_sum,
  output logic [CW-1:0]             beat_cnt
);

  // BSW bits hold PIX worst-case diffs, so the running sum never wraps.
  always_comb begin
    beat_sum = '0;
    beat_cnt = '0;
    for (int i = 0; i < PIX; i++) begin
      if (pix_en[i] && (cate[i*N_CATE_BIT +: N_CATE_BIT] == tgt)) begin
        beat_sum = beat_sum + {{(BSW-DW){diff[i*DW+DW-1]}}, diff[i*DW +: DW]};
        beat_cnt = beat_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sao_stat_accum.sv
// SAO per-category statistics: accumulates diff sums and pixel counts over a CTB,
// then drains one category per handshake.
module sao_stat_accum
  import sao_stat_accum_pkg::*;
#(
  parameter int PIX           = PIX_DEF,
  parameter int DIFF_CLIP_BIT = DIFF_CLIP_BIT_DEF,
  parameter int N_CATE_BIT    = N_CATE_BIT_DEF,
  parameter int SUM_BIT       = SUM_BIT_DEF,
  parameter int CNT_BIT       = CNT_BIT_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_last,
  input  logic [PIX-1:0]                   pix_en,
  input  logic [PIX*N_CATE_BIT-1:0]        cate,
  input  logic [PIX*(DIFF_CLIP_BIT+1)-1:0] diff,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N_CATE_BIT-1:0]            out_cate,
  output logic [SUM_BIT-1:0]               out_sum,
  output logic [CNT_BIT-1:0]               out_cnt,
  output logic                             busy
);

  localparam int N_CATE = 2**N_CATE_BIT;
  localparam int DW     = DIFF_CLIP_BIT + 1;
  localparam int CW     = $clog2(PIX + 1);
  localparam int BSW    = DW + CW;
  localparam int EW     = ((SUM_BIT > BSW) ? SUM_BIT : BSW) + 1;

  localparam logic signed [EW-1:0] SMAX = {{(EW-SUM_BIT+1){1'b0}}, {(SUM_BIT-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {{(EW-SUM_BIT+1){1'b1}}, {(SUM_BIT-1){1'b0}}};

  state_e                state_q, state_d;
  logic [N_CATE_BIT-1:0] idx_q, idx_d;
  logic [SUM_BIT-1:0]    sum_q [N_CATE];
  logic [SUM_BIT-1:0]    sum_d [N_CATE];
  logic [CNT_BIT-1:0]    cnt_q [N_CATE];
  logic [CNT_BIT-1:0]    cnt_d [N_CATE];
  logic [BSW-1:0]        beat_sum [N_CATE];
  logic [CW-1:0]         beat_cnt [N_CATE];
  logic                  clr;
  logic                  acc_en;

  for (genvar k = 0; k < N_CATE; k++) begin : g_lane
    sao_stat_lane_sum #(
      .PIX           (PIX),
      .DIFF_CLIP_BIT (DIFF_CLIP_BIT),
      .N_CATE_BIT    (N_CATE_BIT)
    ) u_lane_sum (
      .tgt      (N_CATE_BIT'(k)),
      .cate     (cate),
      .diff     (diff),
      .pix_en   (pix_en),
      .beat_sum (beat_sum[k]),
      .beat_cnt (beat_cnt[k])
    );
  end

  function automatic logic [SUM_BIT-1:0] sat_sum(input logic [SUM_BIT-1:0] a,
                                                 input logic [BSW-1:0] b);
    logic signed [EW-1:0] t;
    t = $signed({{(EW-SUM_BIT){a[SUM_BIT-1]}}, a}) + $signed({{(EW-BSW){b[BSW-1]}}, b});
    if (t > SMAX)      return SMAX[SUM_BIT-1:0];
    else if (t < SMIN) return SMIN[SUM_BIT-1:0];
    else               return t[SUM_BIT-1:0];
  endfunction

  function automatic logic [CNT_BIT-1:0] sat_cnt(input logic [CNT_BIT-1:0] a,
                                                 input logic [CW-1:0] b);
    logic [CNT_BIT:0] t;
    t = {1'b0, a} + {{(CNT_BIT+1-CW){1'b0}}, b};
    return t[CNT_BIT] ? '1 : t[CNT_BIT-1:0];
  endfunction

  // start wins over a concurrent beat; it is ignored only while draining.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr     = 1'b0;
    acc_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          idx_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (start) begin
          clr = 1'b1;
        end else if (in_valid) begin
          acc_en = 1'b1;
          if (in_last) begin
            idx_d   = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (idx_q == N_CATE_BIT'(N_CATE-1)) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + N_CATE_BIT'(1);
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    for (int k = 0; k < N_CATE; k++) begin
      sum_d[k] = sum_q[k];
      cnt_d[k] = cnt_q[k];
      if (clr) begin
        sum_d[k] = '0;
        cnt_d[k] = '0;
      end else if (acc_en) begin
        sum_d[k] = sat_sum(sum_q[k], beat_sum[k]);
        cnt_d[k] = sat_cnt(cnt_q[k], beat_cnt[k]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      for (int k = 0; k < N_CATE; k++) begin
        sum_q[k] <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int k = 0; k < N_CATE; k++) begin
        sum_q[k] <= sum_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DRAIN);
  assign busy      = (state_q != ST_IDLE);
  assign out_cate  = idx_q;
  assign out_sum   = sum_q[idx_q];
  assign out_cnt   = cnt_q[idx_q];

endmodule

// File: tb/tb_sao_stat_accum.sv
// Randomized self-checking bench for sao_stat_accum (default widths plus an 8-bit-sum instance).
module tb_sao_stat_accum;

  localparam int PIX = 4;
  localparam int NC  = 32;

  typedef int lane_t [PIX];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [3:0]  pix_en = '0;
  logic [19:0] cate = '0, diff = '0;

  logic        in_ready, out_valid, busy;
  logic [4:0]  out_cate;
  logic [15:0] out_sum;
  logic [11:0] out_cnt;
  logic        in_ready8, out_valid8, busy8;
  logic [4:0]  out_cate8;
  logic [7:0]  out_sum8;
  logic [11:0] out_cnt8;

  int checks = 0;
  int errors = 0;
  int m_sum  [NC];
  int m_sum8 [NC];
  int m_cnt  [NC];

  sao_stat_accum dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .pix_en(pix_en), .cate(cate), .diff(diff),
    .out_valid(out_valid), .out_ready(out_ready), .out_cate(out_cate),
    .out_sum(out_sum), .out_cnt(out_cnt), .busy(busy)
  );

  sao_stat_accum #(.SUM_BIT(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready8),
    .in_last(in_last), .pix_en(pix_en), .cate(cate), .diff(diff),
    .out_valid(out_valid8), .out_ready(out_ready), .out_cate(out_cate8),
    .out_sum(out_sum8), .out_cnt(out_cnt8), .busy(busy8)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NC; k++) begin
      m_sum[k] = 0; m_sum8[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_beat(input logic [3:0] en, input lane_t c, input lane_t d);
    int bs [NC];
    int bc [NC];
    for (int k = 0; k < NC; k++) begin bs[k] = 0; bc[k] = 0; end
    for (int i = 0; i < PIX; i++)
      if (en[i]) begin bs[c[i]] += d[i]; bc[c[i]] += 1; end
    for (int k = 0; k < NC; k++) begin
      m_sum[k]  = clamp(m_sum[k] + bs[k], -32768, 32767);
      m_sum8[k] = clamp(m_sum8[k] + bs[k], -128, 127);
      m_cnt[k]  = clamp(m_cnt[k] + bc[k], 0, 4095);
    end
  endtask

  task automatic rand_lanes(output lane_t c, output lane_t d, input int cmax);
    for (int i = 0; i < PIX; i++) begin
      c[i] = int'($urandom_range(0, cmax));
      d[i] = int'($urandom_range(0, 31)) - 16;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    model_clear();
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk);
  endtask

  // Caller guarantees the DUT is in ACCUM when this is called.
  task automatic drive_beat(input logic [3:0] en, input lane_t c, input lane_t d,
                            input bit last, input bit with_start);
    @(negedge clk);
    start = with_start; in_valid = 1'b1; in_last = last; pix_en = en;
    for (int i = 0; i < PIX; i++) begin
      cate[i*5 +: 5] = c[i][4:0];
      diff[i*5 +: 5] = d[i][4:0];
    end
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL accum_ready: in_ready=%b busy=%b, need 1/1", in_ready, busy);
    end
    @(posedge clk);
    if (with_start) model_clear();
    else model_beat(en, c, d);
  endtask

  // Walks all categories; optional stall, start-during-drain and async reset injection.
  task automatic drain(input string tag, input int hold_idx, input int hold_n,
                       input int start_idx, input int rst_idx, input bit rand_rdy);
    int hs = 0, cyc = 0, held = 0;
    bit rdy = 1'b0, prev_stall = 1'b0, aborted = 1'b0;
    logic [4:0]  pc = '0;
    logic [15:0] ps = '0;
    logic [11:0] pn = '0;
    lane_t c, d;
    while (hs < NC && cyc < 400 && !aborted) begin
      @(negedge clk);
      cyc++;
      if (hs == rst_idx) begin
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_cate !== 5'd0 ||
            out_sum !== 16'd0 || out_cnt !== 12'd0) begin
          errors++;
          $display("FAIL %s async_reset: valid=%b busy=%b cate=%0d sum=%0d cnt=%0d, need all 0",
                   tag, out_valid, busy, out_cate, out_sum, out_cnt);
        end
        model_clear();
        aborted = 1'b1;
      end else begin
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || out_cate !== 5'(hs) ||
            $signed(out_sum) !== m_sum[hs] || out_cnt !== m_cnt[hs] ||
            $signed(out_sum8) !== m_sum8[hs] || out_cnt8 !== m_cnt[hs]) begin
          errors++;
          $display("FAIL %s entry: got v=%b rdy=%b cate=%0d sum=%0d cnt=%0d sum8=%0d cnt8=%0d; need v=1 rdy=0 cate=%0d sum=%0d cnt=%0d sum8=%0d",
                   tag, out_valid, in_ready, out_cate, $signed(out_sum), out_cnt,
                   $signed(out_sum8), out_cnt8, hs, m_sum[hs], m_cnt[hs], m_sum8[hs]);
        end
        if (prev_stall) begin
          checks++;
          if (out_cate !== pc || out_sum !== ps || out_cnt !== pn) begin
            errors++;
            $display("FAIL %s stall_stable: got cate=%0d sum=%0d cnt=%0d, need %0d/%0d/%0d",
                     tag, out_cate, out_sum, out_cnt, pc, ps, pn);
          end
        end
        pc = out_cate; ps = out_sum; pn = out_cnt;
        if (hs == hold_idx && held < hold_n) begin
          rdy = 1'b0;
          held++;
        end else begin
          rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        prev_stall = !rdy;
        out_ready  = rdy;
        start      = (hs == start_idx);
        rand_lanes(c, d, 31);
        in_valid = 1'($urandom_range(0, 1));
        in_last  = 1'($urandom_range(0, 1));
        pix_en   = 4'hF;
        for (int i = 0; i < PIX; i++) begin
          cate[i*5 +: 5] = c[i][4:0];
          diff[i*5 +: 5] = d[i][4:0];
        end
        @(posedge clk);
        if (rdy) hs++;
      end
    end
    if (!aborted) begin
      checks++;
      if (hs != NC) begin
        errors++;
        $display("FAIL %s handshakes: got %0d, need %0d", tag, hs, NC);
      end
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s back_to_idle: busy=%b valid=%b in_ready=%b, need 0/0/0",
                 tag, busy, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_cate !== 5'd0 ||
        out_sum !== 16'd0 || out_cnt !== 12'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rdy=%b valid=%b cate=%0d sum=%0d cnt=%0d, need all 0",
               busy, in_ready, out_valid, out_cate, out_sum, out_cnt);
    end
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    in_valid = 1'b1; in_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b rdy=%b valid=%b, need 0/0/0", busy, in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    lane_t c = '{3, 3, 3, 7};
    lane_t d = '{2, -1, 5, -8};
    do_start();
    drive_beat(4'hF, c, d, 1'b1, 1'b0);
    drain("directed", -1, 0, -1, -1, 1'b0);
    do_start();
    drive_beat(4'b0101, c, d, 1'b1, 1'b0);
    drain("pix_en", -1, 0, -1, -1, 1'b0);
  endtask

  task automatic test_random();
    lane_t c, d;
    int nb;
    for (int t = 0; t < 4; t++) begin
      do_start();
      nb = int'($urandom_range(1, 8));
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 2) == 0) idle_cycle();
        rand_lanes(c, d, (t < 2) ? 7 : 31);
        drive_beat(4'($urandom_range(0, 15)), c, d, b == nb - 1, 1'b0);
      end
      drain("random", -1, 0, -1, -1, 1'b1);
    end
  endtask

  task automatic test_saturation();
    lane_t c0 = '{0, 0, 0, 0};
    lane_t c5 = '{5, 5, 5, 5};
    lane_t c9 = '{9, 9, 9, 9};
    lane_t dp = '{15, 15, 15, 15};
    lane_t dn = '{-16, -16, -16, -16};
    lane_t d1 = '{1, 1, 1, 1};
    do_start();
    for (int b = 0; b < 10; b++) drive_beat(4'hF, c0, dp, 1'b0, 1'b0);
    for (int b = 0; b < 10; b++) drive_beat(4'hF, c5, dn, b == 9, 1'b0);
    drain("sum_sat", -1, 0, -1, -1, 1'b0);
    do_start();
    for (int b = 0; b < 1030; b++) drive_beat(4'hF, c9, d1, b == 1029, 1'b0);
    drain("cnt_sat", -1, 0, -1, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    lane_t c, d;
    do_start();
    for (int b = 0; b < 6; b++) begin
      rand_lanes(c, d, 3);
      drive_beat(4'hF, c, d, b == 5, 1'b0);
    end
    drain("backpressure", 2, 5, -1, -1, 1'b0);
  endtask

  task automatic test_start_discard();
    lane_t c2 = '{2, 2, 2, 2};
    lane_t c1 = '{1, 1, 1, 1};
    lane_t d3 = '{3, 3, 3, 3};
    lane_t d4 = '{4, -4, 4, 6};
    do_start();
    drive_beat(4'hF, c2, d3, 1'b0, 1'b0);
    drive_beat(4'hF, c1, d4, 1'b0, 1'b1);
    drive_beat(4'h0, c2, d3, 1'b1, 1'b0);
    drain("start_discard", -1, 0, -1, -1, 1'b0);
    do_start();
    drive_beat(4'hF, c1, d4, 1'b1, 1'b0);
    drain("start_in_drain", -1, 0, 5, -1, 1'b0);
  endtask

  task automatic test_rst_mid_drain();
    lane_t c, d;
    do_start();
    for (int b = 0; b < 4; b++) begin
      rand_lanes(c, d, 15);
      drive_beat(4'hF, c, d, b == 3, 1'b0);
    end
    drain("rst_drain", -1, 0, -1, 10, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet: valid=%b busy=%b, need 0/0", out_valid, busy);
      end
    end
    out_ready = 1'b0;
    do_start();
    rand_lanes(c, d, 31);
    drive_beat(4'h0, c, d, 1'b1, 1'b0);
    drain("after_reset", -1, 0, -1, -1, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_directed();
    test_random();
    test_saturation();
    test_backpressure();
    test_start_discard();
    test_rst_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
